// File: rtl/alu_sequencer_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | alu_sequencer_if : command, ALU and response signals of alu_sequencer   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface alu_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic        cmd_wide;
    logic [63:0] cmd_a;
    logic [63:0] cmd_b;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_opcode;
    logic        alu_sub;
    logic        alu_cin;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic [3:0]  alu_status;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_wide, cmd_a, cmd_b,
        output cmd_ready,
        output alu_a, alu_b, alu_opcode, alu_sub, alu_cin,
        input  alu_result, alu_cout, alu_status,
        output rsp_valid, rsp_result, rsp_flags, rsp_err,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_wide, cmd_a, cmd_b,
        input  cmd_ready,
        input  alu_a, alu_b, alu_opcode, alu_sub, alu_cin,
        output alu_result, alu_cout, alu_status,
        input  rsp_valid, rsp_result, rsp_flags, rsp_err,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | alu_sequencer : issues 32-bit or chained 64-bit ops to a comb. ALU      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module alu_sequencer (
    input  wire logic       clk,
    input  wire logic       rst,
    alu_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [3:0] c_op_sub   = 4'd1;
    localparam logic [2:0] c_alu_idle = 3'b111;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic        wide_q, wide_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic        carry_q, carry_d;
    logic        zlo_q, zlo_d;
    logic [63:0] result_q, result_d;
    logic [3:0]  flags_q, flags_d;
    logic        err_q, err_d;

    logic        w_accept;
    logic        w_illegal;
    logic        w_is_sub;
    logic        w_arith;
    logic [2:0]  w_opcode;

    assign bus.cmd_ready  = (state_q == S_IDLE) && !rst;
    assign w_accept       = bus.cmd_valid && bus.cmd_ready;
    // Shifts have no carry chain, so they cannot be split across two passes.
    assign w_illegal      = bus.cmd_op[3] || (bus.cmd_wide && (bus.cmd_op[2:1] == 2'b11));
    assign w_is_sub       = (op_q == c_op_sub);
    assign w_arith        = (op_q[3:1] == 3'b000);

    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_result = result_q;
    assign bus.rsp_flags  = flags_q;
    assign bus.rsp_err    = err_q;

    always_comb begin
        w_opcode = c_alu_idle;
        case (op_q)
            4'd0, 4'd1: w_opcode = 3'b000;
            4'd2:       w_opcode = 3'b001;
            4'd3:       w_opcode = 3'b010;
            4'd4:       w_opcode = 3'b011;
            4'd5:       w_opcode = 3'b100;
            4'd6:       w_opcode = 3'b101;
            4'd7:       w_opcode = 3'b110;
            default:    w_opcode = c_alu_idle;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        wide_d         = wide_q;
        a_d            = a_q;
        b_d            = b_q;
        carry_d        = carry_q;
        zlo_d          = zlo_q;
        result_d       = result_q;
        flags_d        = flags_q;
        err_d          = err_q;
        bus.alu_opcode = c_alu_idle;
        bus.alu_a      = 32'd0;
        bus.alu_b      = 32'd0;
        bus.alu_sub    = 1'b0;
        bus.alu_cin    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d   = bus.cmd_op;
                    wide_d = bus.cmd_wide;
                    a_d    = bus.cmd_a;
                    b_d    = bus.cmd_b;
                    if (w_illegal) begin
                        result_d = 64'd0;
                        flags_d  = 4'd0;
                        err_d    = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        err_d    = 1'b0;
                        state_d  = S_LO;
                    end
                end
            end
            S_LO: begin
                // Wide SUB inverts B here and injects the +1 as carry-in so the
                // borrow propagates correctly into the high pass.
                bus.alu_opcode = w_opcode;
                bus.alu_a      = a_q[31:0];
                bus.alu_b      = (wide_q && w_is_sub) ? ~b_q[31:0] : b_q[31:0];
                bus.alu_sub    = !wide_q && w_is_sub;
                bus.alu_cin    = wide_q && w_is_sub;
                result_d       = {32'd0, bus.alu_result};
                carry_d        = bus.alu_cout;
                zlo_d          = bus.alu_status[0];
                flags_d        = bus.alu_status;
                state_d        = wide_q ? S_HI : S_RESP;
            end
            S_HI: begin
                bus.alu_opcode = w_opcode;
                bus.alu_a      = a_q[63:32];
                bus.alu_b      = w_is_sub ? ~b_q[63:32] : b_q[63:32];
                bus.alu_cin    = w_arith && carry_q;
                result_d       = {bus.alu_result, result_q[31:0]};
                flags_d        = {bus.alu_status[3:1], bus.alu_status[0] && zlo_q};
                state_d        = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= 4'd0;
            wide_q   <= 1'b0;
            a_q      <= 64'd0;
            b_q      <= 64'd0;
            carry_q  <= 1'b0;
            zlo_q    <= 1'b0;
            result_q <= 64'd0;
            flags_q  <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            wide_q   <= wide_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            zlo_q    <= zlo_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_alu_sequencer : self-checking bench with ALU model and reference     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Combinational 32-bit ALU: A + (sub ? ~B+1 : B) + Cin, flags {o,c,n,z}.
    logic [31:0] m_bb, m_res;
    logic [32:0] m_sum;
    logic        m_co, m_ov;
    always_comb begin
        m_bb  = bus.alu_sub ? ~bus.alu_b : bus.alu_b;
        m_sum = {1'b0, bus.alu_a} + {1'b0, m_bb} + 33'(bus.alu_sub) + 33'(bus.alu_cin);
        m_res = 32'd0;
        m_co  = 1'b0;
        m_ov  = 1'b0;
        case (bus.alu_opcode)
            3'b000: begin
                m_res = m_sum[31:0];
                m_co  = m_sum[32];
                m_ov  = (bus.alu_a[31] == m_bb[31]) && (m_res[31] != bus.alu_a[31]);
            end
            3'b001:  m_res = bus.alu_a ^ bus.alu_b;
            3'b010:  m_res = bus.alu_a & bus.alu_b;
            3'b011:  m_res = bus.alu_a | bus.alu_b;
            3'b100:  m_res = ~(bus.alu_a | bus.alu_b);
            3'b101:  m_res = bus.alu_a << bus.alu_b[4:0];
            3'b110:  m_res = bus.alu_a >> bus.alu_b[4:0];
            default: m_res = 32'd0;
        endcase
        bus.alu_result = m_res;
        bus.alu_cout   = m_co;
        bus.alu_status = {m_ov, m_co, m_res[31], (m_res == 32'd0)};
    end

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] lo_b;
    logic        lo_cin, hi_cin, saw_active;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Whole-operand reference: plain 32/64-bit arithmetic, no pass splitting.
    function automatic void ref_model(input logic [3:0] op, input logic wide,
                                      input logic [63:0] a, input logic [63:0] b,
                                      output logic [63:0] r, output logic [3:0] f,
                                      output logic e);
        logic [64:0] s;
        logic [32:0] t;
        logic        c, o;
        r = 64'd0; f = 4'd0; e = 1'b0; c = 1'b0; o = 1'b0;
        if (op > 4'd7 || (wide && op >= 4'd6)) begin
            e = 1'b1;
            return;
        end
        if (wide) begin
            case (op)
                4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[63:0]; c = s[64];
                            o = (a[63] == b[63]) && (r[63] != a[63]); end
                4'd1: begin r = a - b; c = (a >= b);
                            o = (a[63] != b[63]) && (r[63] != a[63]); end
                4'd2: r = a ^ b;
                4'd3: r = a & b;
                4'd4: r = a | b;
                default: r = ~(a | b);
            endcase
            f = {o, c, r[63], (r == 64'd0)};
        end else begin
            case (op)
                4'd0: begin t = {1'b0, a[31:0]} + {1'b0, b[31:0]}; c = t[32];
                            o = (a[31] == b[31]) && (t[31] != a[31]); end
                4'd1: begin t = {1'b0, a[31:0] - b[31:0]}; c = (a[31:0] >= b[31:0]);
                            o = (a[31] != b[31]) && (t[31] != a[31]); end
                4'd2: t = {1'b0, a[31:0] ^ b[31:0]};
                4'd3: t = {1'b0, a[31:0] & b[31:0]};
                4'd4: t = {1'b0, a[31:0] | b[31:0]};
                4'd5: t = {1'b0, ~(a[31:0] | b[31:0])};
                4'd6: t = {1'b0, a[31:0] << b[4:0]};
                default: t = {1'b0, a[31:0] >> b[4:0]};
            endcase
            r = {32'd0, t[31:0]};
            f = {o, c, t[31], (t[31:0] == 32'd0)};
        end
    endfunction

    task automatic run_op(input string name, input logic [3:0] op, input logic wide,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] er, input logic [3:0] ef, input logic ee,
                          input int stall);
        int n, lat, exp_lat;
        logic [63:0] hold_r;
        logic [3:0]  hold_f;
        exp_lat = ee ? 0 : (wide ? 2 : 1);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_wide = wide;
        bus.cmd_a = a; bus.cmd_b = b;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
        chk({name, " cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 4'($urandom); bus.cmd_wide = 1'($urandom);
        bus.cmd_a = {$urandom, $urandom}; bus.cmd_b = {$urandom, $urandom};
        @(negedge clk);
        lat = 0;
        lo_b = bus.alu_b; lo_cin = bus.alu_cin;
        saw_active = (bus.alu_opcode != 3'b111);
        while (!bus.rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
            if (lat == 1) hi_cin = bus.alu_cin;
            if (bus.alu_opcode != 3'b111) saw_active = 1'b1;
        end
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " result"}, bus.rsp_result, er);
        chk({name, " flags"}, 64'(bus.rsp_flags), 64'(ef));
        chk({name, " err"}, 64'(bus.rsp_err), 64'(ee));
        chk({name, " alu used"}, 64'(saw_active), 64'(!ee));
        hold_r = bus.rsp_result; hold_f = bus.rsp_flags;
        bus.cmd_valid = (stall > 0);
        bus.cmd_op = 4'd2; bus.cmd_wide = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({name, " stall valid"}, 64'(bus.rsp_valid), 64'd1);
            chk({name, " stall result"}, bus.rsp_result, hold_r);
            chk({name, " stall flags"}, 64'(bus.rsp_flags), 64'(hold_f));
            chk({name, " stall cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
            chk({name, " stall alu idle"}, 64'(bus.alu_opcode), 64'd7);
        end
        bus.rsp_ready = 1'b1; bus.cmd_valid = 1'b0;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({name, " post valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({name, " post cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        wide;
        logic [63:0] a, b, r;
        logic [3:0]  f;
        logic        e;
        int          stall;
    } vec_t;
    vec_t tbl[16];

    initial begin
        logic [63:0] ra, rb, rr;
        logic [3:0]  rf, rop;
        logic        re, rw;

        tbl[0]  = '{4'd0, 1'b0, 64'h7FFFFFFF, 64'h1, 64'h80000000, 4'b1010, 1'b0, 0};
        tbl[1]  = '{4'd0, 1'b1, 64'hFFFFFFFF, 64'h1, 64'h1_00000000, 4'b0000, 1'b0, 0};
        tbl[2]  = '{4'd1, 1'b1, 64'h1_00000000, 64'h1_00000000, 64'h0, 4'b0101, 1'b0, 0};
        tbl[3]  = '{4'd1, 1'b0, 64'h5, 64'h7, 64'hFFFFFFFE, 4'b0010, 1'b0, 1};
        tbl[4]  = '{4'd2, 1'b0, 64'hF0F0F0F0, 64'hFFFFFFFF, 64'h0F0F0F0F, 4'b0000, 1'b0, 0};
        tbl[5]  = '{4'd3, 1'b0, 64'hFFFF0000, 64'h0000FFFF, 64'h0, 4'b0001, 1'b0, 0};
        tbl[6]  = '{4'd5, 1'b0, 64'h0, 64'h0, 64'hFFFFFFFF, 4'b0010, 1'b0, 0};
        tbl[7]  = '{4'd6, 1'b0, 64'h1, 64'd31, 64'h80000000, 4'b0010, 1'b0, 0};
        tbl[8]  = '{4'd7, 1'b0, 64'h80000000, 64'd4, 64'h08000000, 4'b0000, 1'b0, 0};
        tbl[9]  = '{4'hA, 1'b0, 64'h1234, 64'h5678, 64'h0, 4'b0000, 1'b1, 0};
        tbl[10] = '{4'd6, 1'b1, 64'h1, 64'h1, 64'h0, 4'b0000, 1'b1, 2};
        tbl[11] = '{4'd4, 1'b1, 64'hF0000000_00000000, 64'h1, 64'hF0000000_00000001, 4'b0010, 1'b0, 0};
        tbl[12] = '{4'd1, 1'b1, 64'h0, 64'h1, 64'hFFFFFFFF_FFFFFFFF, 4'b0010, 1'b0, 0};
        tbl[13] = '{4'd0, 1'b0, 64'hDEADBEEF_00000001, 64'h12345678_00000002, 64'h3, 4'b0000, 1'b0, 5};
        tbl[14] = '{4'd1, 1'b0, 64'h3, 64'h3, 64'h0, 4'b0101, 1'b0, 0};
        tbl[15] = '{4'd0, 1'b1, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 64'h80000000_00000000, 4'b1010, 1'b0, 0};

        bus.cmd_valid = 1'b0; bus.cmd_op = 4'd0; bus.cmd_wide = 1'b0;
        bus.cmd_a = 64'd0; bus.cmd_b = 64'd0; bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst rsp_result", bus.rsp_result, 64'd0);
        chk("rst rsp_flags", 64'(bus.rsp_flags), 64'd0);
        chk("rst rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst alu_opcode", 64'(bus.alu_opcode), 64'd7);
        chk("rst alu_a", 64'(bus.alu_a), 64'd0);
        rst = 1'b0;
        #1;
        chk("post-rst cmd_ready", 64'(bus.cmd_ready), 64'd1);

        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].wide, tbl[i].a, tbl[i].b,
                   tbl[i].r, tbl[i].f, tbl[i].e, tbl[i].stall);
        end

        run_op("wadd", 4'd0, 1'b1, 64'hFFFFFFFF, 64'h1, 64'h1_00000000, 4'b0000, 1'b0, 0);
        chk("wadd hi cin", 64'(hi_cin), 64'd1);
        run_op("wsub", 4'd1, 1'b1, 64'h1_00000000, 64'h1_00000000, 64'h0, 4'b0101, 1'b0, 0);
        chk("wsub lo alu_b", 64'(lo_b), 64'hFFFFFFFF);
        chk("wsub lo cin", 64'(lo_cin), 64'd1);

        // Abort a wide ADD during its HI pass.
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 4'd0; bus.cmd_wide = 1'b1;
        bus.cmd_a = 64'hFFFFFFFF; bus.cmd_b = 64'h1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort in HI", 64'(bus.alu_a), 64'd0);
        chk("abort hi cin", 64'(bus.alu_cin), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort cmd_ready", 64'(bus.cmd_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort no rsp", 64'(bus.rsp_valid), 64'd0);
        end
        run_op("xor after abort", 4'd2, 1'b0, 64'hF0F0F0F0, 64'hFFFFFFFF,
               64'h0F0F0F0F, 4'b0000, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 9));
            if (rop >= 4'd8) rop = 4'(8 + $urandom_range(0, 7));
            rw = 1'($urandom_range(0, 1));
            ra = {$urandom, $urandom};
            rb = ($urandom_range(0, 5) == 0) ? ra : {$urandom, $urandom};
            ref_model(rop, rw, ra, rb, rr, rf, re);
            run_op($sformatf("rnd%0d op%0d w%0d", i, rop, rw), rop, rw, ra, rb, rr, rf, re,
                   int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
